// File: rtl/psum_collector_pkg.sv
// Shared sizes and requantization helper for the PE-array output stages.
package psum_collector_pkg;

  localparam int unsigned DATA_SIZE        = 8;
  localparam int unsigned BIGGER_DATA_SIZE = 10;
  localparam int unsigned ACC_SIZE         = 16;

  // Arithmetic right shift, then clamp to the signed range of data_w bits.
  function automatic logic signed [31:0] sat_requant(input logic signed [31:0] acc,
                                                     input int unsigned        shift,
                                                     input int unsigned        data_w);
    logic signed [31:0] q;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    q  = acc >>> shift;
    hi = (32'sd1 <<< (data_w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (data_w - 1));
    if (q > hi) begin
      return hi;
    end else if (q < lo) begin
      return lo;
    end
    return q;
  endfunction

endpackage

// File: rtl/psum_collector_if.sv
// Psum input stream and ofmap valid/ready output stream of the collector.
interface psum_collector_if import psum_collector_pkg::*; #(
  parameter int unsigned DATA_W = DATA_SIZE,
  parameter int unsigned PSUM_W = BIGGER_DATA_SIZE
) ();

  logic [PSUM_W-1:0] psum;
  logic              psum_valid;
  logic [DATA_W-1:0] ofmap;
  logic              ofmap_valid;
  logic              ofmap_ready;

  modport master (
    output psum, psum_valid, ofmap_ready,
    input  ofmap, ofmap_valid
  );

  modport slave (
    input  psum, psum_valid, ofmap_ready,
    output ofmap, ofmap_valid
  );

endinterface

// File: rtl/psum_collector_ofmap_fifo.sv
// First-word-fall-through FIFO for finished ofmap values, with registered count.
module psum_collector_ofmap_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(FIFO_DEPTH));

  // A push into a full FIFO is only taken when a pop frees a slot this cycle.
  assign do_pop  = pop_i & ~empty_o & ~clear_i;
  assign do_push = push_i & (~full_o | do_pop) & ~clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop) count_d = count_q + CW'(1);
      if (!do_push && do_pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= data_i;
  end

  assign data_o = empty_o ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/psum_collector.sv
// Accumulates column psums over CHANNELS passes, applies ReLU/requantization
// and queues finished ofmap values behind a valid/ready interface.
module psum_collector import psum_collector_pkg::*; #(
  parameter int unsigned DATA_W     = DATA_SIZE,
  parameter int unsigned PSUM_W     = BIGGER_DATA_SIZE,
  parameter int unsigned ACC_W      = ACC_SIZE,
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned SHIFT      = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  psum_collector_if.slave     bus,
  input  logic                clear_i,
  input  logic                relu_en_i,
  output logic                overflow_o,
  output logic                busy_o
);

  localparam int unsigned CNT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic        [CNT_W-1:0] ch_cnt_q, ch_cnt_d;
  logic                    overflow_q, overflow_d;
  logic signed [ACC_W-1:0] ext, sum, relu_v;
  logic signed [31:0]      q32;
  logic                    last, push, pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0]       ofmap_data;
  logic [DATA_W-1:0]       requant;
  logic                    unused_q;

  assign ext  = ACC_W'($signed(bus.psum));
  assign last = (ch_cnt_q == CNT_W'(CHANNELS - 1));
  assign sum  = (ch_cnt_q == '0) ? ext : acc_q + ext;
  assign pop  = bus.ofmap_valid & bus.ofmap_ready;

  always_comb begin
    relu_v   = (relu_en_i && (sum < 0)) ? '0 : sum;
    q32      = sat_requant(32'(relu_v), SHIFT, DATA_W);
    requant  = q32[DATA_W-1:0];
    unused_q = ^q32[31:DATA_W];
  end

  always_comb begin
    acc_d      = acc_q;
    ch_cnt_d   = ch_cnt_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    if (clear_i) begin
      acc_d      = '0;
      ch_cnt_d   = '0;
      overflow_d = 1'b0;
    end else if (bus.psum_valid) begin
      if (last) begin
        acc_d    = '0;
        ch_cnt_d = '0;
        push     = 1'b1;
      end else begin
        acc_d    = sum;
        ch_cnt_d = ch_cnt_q + CNT_W'(1);
      end
    end
    // Result lost: FIFO full and no slot freed this cycle.
    if (push && fifo_full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      acc_q      <= '0;
      ch_cnt_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      ch_cnt_q   <= ch_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  psum_collector_ofmap_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .clear_i (clear_i),
    .push_i  (push),
    .data_i  (requant),
    .pop_i   (pop),
    .data_o  (ofmap_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.ofmap       = ofmap_data;
  assign bus.ofmap_valid = ~fifo_empty;
  assign overflow_o      = overflow_q;
  assign busy_o          = (ch_cnt_q != '0) | ~fifo_empty;

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector with a queue-based reference model.
module tb_psum_collector;

  localparam int CH    = 3;
  localparam int SH    = 2;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rstn  = 1'b1;
  logic clear = 1'b0;
  logic relu  = 1'b0;
  logic overflow, busy;

  psum_collector_if #(.DATA_W(8), .PSUM_W(10)) bus ();

  psum_collector #(
    .DATA_W     (8),
    .PSUM_W     (10),
    .ACC_W      (16),
    .CHANNELS   (CH),
    .SHIFT      (SH),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .bus        (bus),
    .clear_i    (clear),
    .relu_en_i  (relu),
    .overflow_o (overflow),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: running sum, psum count, queue of pending ofmap values.
  int m_acc = 0;
  int m_n   = 0;
  int m_q[$];
  bit m_ov  = 1'b0;

  initial begin
    bit popping;
    bit have;
    int v;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        m_acc = 0; m_n = 0; m_q.delete(); m_ov = 1'b0;
      end else if (clear) begin
        m_acc = 0; m_n = 0; m_q.delete(); m_ov = 1'b0;
      end else begin
        popping = bus.ofmap_ready && (m_q.size() != 0);
        have    = 1'b0;
        v       = 0;
        if (bus.psum_valid) begin
          m_acc += int'($signed(bus.psum));
          m_n++;
          if (m_n == CH) begin
            v = (relu && m_acc < 0) ? 0 : m_acc;
            v = v >>> SH;
            if (v > 127)  v = 127;
            if (v < -128) v = -128;
            have  = 1'b1;
            m_acc = 0;
            m_n   = 0;
          end
        end
        if (popping) void'(m_q.pop_front());
        if (have) begin
          if (m_q.size() < DEPTH) m_q.push_back(v);
          else m_ov = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        chk("rst_valid", bus.ofmap_valid, 0);
        chk("rst_ofmap", bus.ofmap, 0);
      end else begin
        chk("valid", bus.ofmap_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk("ofmap", $signed(bus.ofmap), m_q[0]);
        chk("overflow", overflow, m_ov);
        chk("busy", busy, (m_n != 0) || (m_q.size() != 0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input int p);
    bus.psum       = 10'(p);
    bus.psum_valid = 1'b1;
    @(negedge clk);
    bus.psum_valid = 1'b0;
  endtask

  task automatic send3(input int a, input int b, input int c);
    send(a); send(b); send(c);
  endtask

  initial begin
    int exp4[4];
    bus.psum        = '0;
    bus.psum_valid  = 1'b0;
    bus.ofmap_ready = 1'b1;
    #1 rstn = 1'b0;
    #1;
    chk("reset_valid", bus.ofmap_valid, 0);
    chk("reset_ofmap", bus.ofmap, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_busy", busy, 0);
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);

    // 1: basic accumulation, valid one cycle after the final psum
    send(100); send(200);
    chk("t1_not_yet_valid", bus.ofmap_valid, 0);
    send(-50);
    chk("t1_valid", bus.ofmap_valid, 1);
    chk("t1_ofmap", $signed(bus.ofmap), 62);
    @(negedge clk);

    // 2: ReLU on/off and negative saturation
    relu = 1'b1;
    send3(-300, -200, -100);
    chk("t2_relu_ofmap", $signed(bus.ofmap), 0);
    relu = 1'b0;
    @(negedge clk);
    send3(-300, -200, -100);
    chk("t2_neg_sat", $signed(bus.ofmap), -128);
    @(negedge clk);

    // 3: positive saturation
    send3(511, 511, 511);
    chk("t3_pos_sat", $signed(bus.ofmap), 127);
    @(negedge clk);

    // 4: FIFO fills, fifth result dropped, drain in order, clear
    bus.ofmap_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send3(4 * k, 4 * k, 4 * k);
    chk("t4_overflow", overflow, 1);
    bus.ofmap_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("t4_drain", $signed(bus.ofmap), 3 * k);
      @(negedge clk);
    end
    chk("t4_empty", bus.ofmap_valid, 0);
    chk("t4_overflow_sticky", overflow, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("t4_overflow_clear", overflow, 0);

    // 5: push and pop on a full FIFO in the same cycle
    bus.ofmap_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send3(4 * k, 4 * k, 4 * k);
    send(20); send(20);
    bus.ofmap_ready = 1'b1;
    send(20);
    chk("t5_overflow", overflow, 0);
    exp4 = '{6, 9, 12, 15};
    for (int k = 0; k < 4; k++) begin
      chk("t5_drain", $signed(bus.ofmap), exp4[k]);
      @(negedge clk);
    end
    chk("t5_empty", bus.ofmap_valid, 0);

    // 6: async reset mid-accumulation
    bus.ofmap_ready = 1'b0;
    send3(4, 4, 4);
    send(7); send(7);
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_valid", bus.ofmap_valid, 0);
    chk("t6_rst_ofmap", bus.ofmap, 0);
    chk("t6_rst_overflow", overflow, 0);
    chk("t6_rst_busy", busy, 0);
    #1 rstn = 1'b1;
    @(negedge clk);
    send3(4, 4, 4);
    chk("t6_fresh_valid", bus.ofmap_valid, 1);
    chk("t6_fresh_ofmap", $signed(bus.ofmap), 3);
    bus.ofmap_ready = 1'b1;
    repeat (2) @(negedge clk);

    // 7: clear with psum_valid in the same cycle
    bus.ofmap_ready = 1'b0;
    send3(8, 8, 8);
    send(4);
    clear = 1'b1;
    send(100);
    clear = 1'b0;
    chk("t7_fifo_empty", bus.ofmap_valid, 0);
    chk("t7_busy", busy, 0);
    send(8); send(8);
    chk("t7_partial", bus.ofmap_valid, 0);
    send(8);
    chk("t7_valid", bus.ofmap_valid, 1);
    chk("t7_ofmap", $signed(bus.ofmap), 6);
    bus.ofmap_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
